// File: rtl/router_sync_multi.sv
// Address latch, write steering, full-flag return and per-channel read-timeout
// soft resets between the router FSM and NUM_PORTS output FIFOs.
module router_sync_multi #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    din,
    input  logic                 detect_addr,
    input  logic                 wr_en_reg,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] rd_en,
    output logic [NUM_PORTS-1:0] wr_en,
    output logic                 fifo_full,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 addr_err
);

    localparam int                 CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TIMEOUT - 1);
    // One extra bit so NUM_PORTS == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]    NUM_PORTS_W = (ADDR_W + 1)'(NUM_PORTS);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_valid;
    logic [CNT_W-1:0]  cnt [NUM_PORTS];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= '0;
            addr_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else if (detect_addr) begin
            addr_q <= din;
            if ({1'b0, din} < NUM_PORTS_W) begin
                addr_valid <= 1'b1;
                addr_err   <= 1'b0;
            end else begin
                addr_valid <= 1'b0;
                addr_err   <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wr_en     = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_valid && (addr_q == ADDR_W'(i))) begin
                wr_en[i]  = wr_en_reg;
                fifo_full = full[i];
            end
        end
    end

    assign vld_out = ~empty;

    // NOTE: the counter array is a handful of flops, not a RAM, so it is
    // cleared by reset like any other control state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            soft_reset <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (vld_out[i] && !rd_en[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        cnt[i]        <= '0;
                        soft_reset[i] <= 1'b1;
                    end else begin
                        cnt[i]        <= cnt[i] + 1'b1;
                        soft_reset[i] <= 1'b0;
                    end
                end else begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/router_sync_multi.md
Name: router_sync_multi

Overview:
- Parametrised successor to the 1x3 router synchronizer; sits between the router FSM/register block and NUM_PORTS output FIFOs.
- Latches the destination address on detect_addr and steers the single write strobe to the addressed FIFO.
- Returns the addressed FIFO's full flag, generates per-channel valid outputs, and issues per-channel soft resets after a programmable read timeout.
- New behaviour: arbitrary channel count, parametrised timeout, out-of-range address detection with packet discard.

Parameters:
NUM_PORTS, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, width of address input din; must satisfy 2**ADDR_W >= NUM_PORTS
TIMEOUT, 30, consecutive unread-valid cycles before soft_reset pulses (>=2); counter width is localparam CNT_W = $clog2(TIMEOUT)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
din  input  ADDR_W  destination address from header byte
detect_addr  input  1  address-capture strobe from router FSM
wr_en_reg  input  1  write request from router FSM
full  input  NUM_PORTS  per-FIFO full flags
empty  input  NUM_PORTS  per-FIFO empty flags
rd_en  input  NUM_PORTS  per-FIFO read enables from destinations
wr_en  output  NUM_PORTS  one-hot write enable to FIFOs
fifo_full  output  1  full flag of currently addressed FIFO
vld_out  output  NUM_PORTS  per-channel data-valid to destinations
soft_reset  output  NUM_PORTS  per-channel one-cycle FIFO flush pulse
addr_err  output  1  latched address out of range

Behaviour:
- Synchronous reset (rst==0 at rising edge): addr_q=0, addr_valid=0, addr_err=0, all timeout counters=0, soft_reset=0. Combinational outputs follow the cleared registers: wr_en=0, fifo_full=0. vld_out stays combinational from empty.
- Address capture: on an edge with detect_addr=1, addr_q<=din.
  - din<NUM_PORTS: addr_valid<=1, addr_err<=0.
  - Otherwise: addr_valid<=0, addr_err<=1.
  - Without detect_addr, all three hold.
- wr_en[i] = wr_en_reg & addr_valid & (addr_q==i); zero-latency combinational; at most one bit set.
  - With addr_err=1, all writes are dropped (packet discarded).
- fifo_full = addr_valid & full[addr_q]; 0 when addr_valid=0, so the FSM drains an invalid packet without stalling.
- Same-cycle detect_addr and wr_en_reg: wr_en uses the pre-edge addr_q. The new address applies from the next cycle.
- vld_out[i] = ~empty[i], combinational, independent of address.
- Per-channel timeout counter cnt[i] (CNT_W bits), evaluated each edge:
  - vld_out[i]=1 and rd_en[i]=0, cnt[i]<TIMEOUT-1: cnt[i]<=cnt[i]+1, soft_reset[i]<=0.
  - vld_out[i]=1 and rd_en[i]=0, cnt[i]==TIMEOUT-1: cnt[i]<=0, soft_reset[i]<=1.
  - rd_en[i]=1 or vld_out[i]=0: cnt[i]<=0, soft_reset[i]<=0.
- Resulting timing:
  - soft_reset[i] is high for exactly one cycle, starting after the TIMEOUT-th consecutive idle-valid edge.
  - If the channel stays idle-valid, the next pulse follows TIMEOUT edges later.
  - Any single read cycle restarts the count from 0.
- Channels are fully independent; several soft_reset bits may pulse in the same cycle.
- Mid-operation reset: counters, address and pulses clear at that edge. An in-flight pulse ends. No write reaches any FIFO while addr_valid=0.
- The counter never wraps past TIMEOUT-1.

Test Plan:
- Reset then default: rst=0 one edge, wr_en_reg=1 -> wr_en=0, fifo_full=0, soft_reset=0, addr_err=0.
- Routing: rst=1, din=2, detect_addr=1 one edge, then wr_en_reg=1, full=3'b100 -> wr_en=3'b100, fifo_full=1. Then full=3'b000 -> fifo_full=0.
- Invalid address (NUM_PORTS=3): din=3 with detect_addr -> addr_err=1, wr_en=0 and fifo_full=0 with wr_en_reg=1. Next din=1 with detect_addr -> addr_err=0, wr_en=3'b010.
- Timeout: empty=3'b110, rd_en=0 -> vld_out=3'b001. soft_reset[0] rises after the 30th edge, is high exactly one cycle, and pulses again 30 edges later.
- Read restart: same setup with rd_en[0]=1 on edge 29 -> no pulse at edge 30; pulse only after 30 further idle edges.
- Simultaneous: channels 0 and 2 idle-valid from the same cycle -> soft_reset=3'b101 in the same cycle. Assert rst=0 at edge 15 -> counters restart, first pulse 30 edges after rst returns to 1.
